// File: rtl/pe_v3.sv
// Systolic-array processing element: double-buffered weight, two-stage MAC,
// weight-stationary pass-through adder or output-stationary accumulator with drain.
module pe_v3 #(
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 32,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode_i,
  input  logic [DATA_WIDTH-1:0] weight_i,
  input  logic                  weight_load_i,
  input  logic                  weight_swap_i,
  input  logic [DATA_WIDTH-1:0] ifmap_i,
  input  logic                  ifmap_vld_i,
  input  logic [PSUM_WIDTH-1:0] psum_i,
  input  logic                  psum_vld_i,
  input  logic                  acc_clr_i,
  input  logic                  drain_i,
  output logic [DATA_WIDTH-1:0] weight_o,
  output logic                  weight_load_o,
  output logic                  weight_swap_o,
  output logic [DATA_WIDTH-1:0] ifmap_o,
  output logic                  ifmap_vld_o,
  output logic [PSUM_WIDTH-1:0] psum_o,
  output logic                  psum_vld_o,
  output logic                  busy_o,
  output logic                  ovf_o
);

  typedef logic [PSUM_WIDTH-1:0] psum_t;
  typedef enum logic [1:0] {ST_WS, ST_OS_ACC, ST_OS_FLUSH, ST_OS_DRAIN} state_t;

  state_t                    state_r;
  logic [DATA_WIDTH-1:0]     active_r;
  logic [2*DATA_WIDTH-1:0]   prod_r;
  logic                      prod_vld_r;
  psum_t                     psum_r;
  psum_t                     acc_r;
  logic [2*DATA_WIDTH-1:0]   ifm_x_s;
  logic [2*DATA_WIDTH-1:0]   wgt_x_s;
  logic [2*DATA_WIDTH-1:0]   prod_s;
  psum_t                     prod_ext_s;
  logic [PSUM_WIDTH:0]       ws_sum_s;
  logic [PSUM_WIDTH:0]       acc_sum_s;

  function automatic psum_t extend(input logic [2*DATA_WIDTH-1:0] p);
    psum_t r;
    if (SIGNED != 0) r = psum_t'($signed(p));
    else             r = psum_t'(p);
    return r;
  endfunction

  // Returns {overflow, result}; result is clamped or wrapped as configured.
  function automatic logic [PSUM_WIDTH:0] add_sat(input psum_t a, input psum_t b);
    logic [PSUM_WIDTH:0] sum;
    logic                ov;
    psum_t               res;
    if (SIGNED != 0) begin
      sum = {a[PSUM_WIDTH-1], a} + {b[PSUM_WIDTH-1], b};
      ov  = sum[PSUM_WIDTH] ^ sum[PSUM_WIDTH-1];
      if (ov && (SATURATE != 0))
        res = sum[PSUM_WIDTH] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}} : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
      else
        res = sum[PSUM_WIDTH-1:0];
    end else begin
      sum = {1'b0, a} + {1'b0, b};
      ov  = sum[PSUM_WIDTH];
      if (ov && (SATURATE != 0)) res = {PSUM_WIDTH{1'b1}};
      else                       res = sum[PSUM_WIDTH-1:0];
    end
    return {ov, res};
  endfunction

  // Multiplier operands extended to product width, then the two adders.
  always_comb begin
    if (SIGNED != 0) begin
      ifm_x_s = (2*DATA_WIDTH)'($signed(ifmap_i));
      wgt_x_s = (2*DATA_WIDTH)'($signed(active_r));
    end else begin
      ifm_x_s = (2*DATA_WIDTH)'(ifmap_i);
      wgt_x_s = (2*DATA_WIDTH)'(active_r);
    end
    prod_s     = ifm_x_s * wgt_x_s;
    prod_ext_s = extend(prod_r);
    ws_sum_s   = add_sat(prod_ext_s, psum_r);
    acc_sum_s  = add_sat(acc_r, prod_ext_s);
  end

  // Weight buffer, forwarding and stage A registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_o      <= '0;
      active_r      <= '0;
      weight_load_o <= 1'b0;
      weight_swap_o <= 1'b0;
      ifmap_o       <= '0;
      ifmap_vld_o   <= 1'b0;
      prod_r        <= '0;
      prod_vld_r    <= 1'b0;
      psum_r        <= '0;
    end else begin
      if (weight_load_i) weight_o <= weight_i;
      if (weight_swap_i) active_r <= weight_o;
      weight_load_o <= weight_load_i;
      weight_swap_o <= weight_swap_i;
      if (ifmap_vld_i) begin
        ifmap_o <= ifmap_i;
        prod_r  <= prod_s;
      end
      ifmap_vld_o <= ifmap_vld_i;
      prod_vld_r  <= ifmap_vld_i;
      psum_r      <= psum_vld_i ? psum_i : '0;
    end
  end

  // Mode FSM with stage B / accumulator and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_WS;
      acc_r      <= '0;
      psum_o     <= '0;
      psum_vld_o <= 1'b0;
      busy_o     <= 1'b0;
      ovf_o      <= 1'b0;
    end else begin
      psum_vld_o <= 1'b0;
      case (state_r)
        ST_WS: begin
          busy_o <= 1'b0;
          if (prod_vld_r) begin
            psum_o     <= ws_sum_s[PSUM_WIDTH-1:0];
            psum_vld_o <= 1'b1;
            if (ws_sum_s[PSUM_WIDTH]) ovf_o <= 1'b1;
          end
          if (mode_i) begin
            state_r <= ST_OS_ACC;
            acc_r   <= '0;
          end
        end
        ST_OS_ACC: begin
          if (psum_vld_i) psum_o <= psum_i;
          psum_vld_o <= psum_vld_i;
          if (acc_clr_i) begin
            acc_r <= prod_vld_r ? prod_ext_s : '0;
            ovf_o <= 1'b0;
          end else if (prod_vld_r) begin
            acc_r <= acc_sum_s[PSUM_WIDTH-1:0];
            if (acc_sum_s[PSUM_WIDTH]) ovf_o <= 1'b1;
          end
          if (!mode_i) begin
            state_r <= ST_WS;
            busy_o  <= 1'b0;
          end else if (drain_i) begin
            state_r <= ST_OS_FLUSH;
            busy_o  <= 1'b1;
          end else begin
            busy_o  <= 1'b0;
          end
        end
        ST_OS_FLUSH: begin
          if (psum_vld_i) psum_o <= psum_i;
          psum_vld_o <= psum_vld_i;
          if (prod_vld_r) begin
            acc_r <= acc_sum_s[PSUM_WIDTH-1:0];
            if (acc_sum_s[PSUM_WIDTH]) ovf_o <= 1'b1;
          end
          state_r <= ST_OS_DRAIN;
          busy_o  <= 1'b1;
        end
        ST_OS_DRAIN: begin
          // An upstream word arriving now is dropped: the own drain owns the output.
          psum_o     <= acc_r;
          psum_vld_o <= 1'b1;
          acc_r      <= prod_vld_r ? prod_ext_s : '0;
          state_r    <= ST_OS_ACC;
          busy_o     <= 1'b0;
        end
        default: begin
          state_r <= ST_WS;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pe_v3.md
PE_V3 -- requirements
Module: pe_v3

Interface
REQ-001 Parameter DATA_WIDTH, default 8, ifmap/weight operand width.
REQ-002 Parameter PSUM_WIDTH, default 32, partial-sum/accumulator width; SHALL be >= 2*DATA_WIDTH.
REQ-003 Parameter SIGNED, default 1; 1 = two's-complement operands and sums, 0 = unsigned.
REQ-004 Parameter SATURATE, default 1; 1 = clamp sums at PSUM_WIDTH bounds, 0 = wrap.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 mode_i  in  1  0 = weight-stationary (WS), 1 = output-stationary (OS).
REQ-008 weight_i / weight_load_i / weight_swap_i  in  DATA_WIDTH/1/1  weight data, shadow-load strobe, shadow-to-active swap strobe.
REQ-009 ifmap_i / ifmap_vld_i  in  DATA_WIDTH/1  activation and valid.
REQ-010 psum_i / psum_vld_i  in  PSUM_WIDTH/1  upstream partial sum and valid.
REQ-011 acc_clr_i / drain_i  in  1/1  OS accumulator clear; OS drain request.
REQ-012 weight_o, weight_load_o, weight_swap_o  out  DATA_WIDTH/1/1  shadow weight and strobes forwarded to next PE.
REQ-013 ifmap_o, ifmap_vld_o  out  DATA_WIDTH/1  registered activation forward.
REQ-014 psum_o, psum_vld_o  out  PSUM_WIDTH/1  registered result and valid.
REQ-015 busy_o  out  1  high in OS_FLUSH/OS_DRAIN; ovf_o  out  1  sticky saturation flag.

Function
REQ-016 Weight double buffer: weight_load_i -> shadow <= weight_i; weight_swap_i -> active <= shadow; both in the same cycle -> active gets old shadow, shadow gets new weight_i.
REQ-017 weight_o = shadow; weight_load_o, weight_swap_o = inputs delayed 1 cycle; ifmap_o, ifmap_vld_o = inputs delayed 1 cycle (ifmap_o updates only when ifmap_vld_i).
REQ-018 Stage A: when ifmap_vld_i, prod_r <= ifmap_i * active (2*DATA_WIDTH, signedness per SIGNED); prod_vld_r <= ifmap_vld_i every cycle.
REQ-019 Products are sign-/zero-extended to PSUM_WIDTH before any addition.
REQ-020 FSM states: WS, OS_ACC, OS_FLUSH, OS_DRAIN; reset state WS.
REQ-021 WS -> OS_ACC when mode_i=1; OS_ACC -> WS when mode_i=0; entry into OS_ACC clears accumulator; mode_i ignored in OS_FLUSH/OS_DRAIN.
REQ-022 WS: stage A also registers psum_r <= psum_vld_i ? psum_i : 0; stage B psum_o <= prod_r + psum_r, psum_vld_o <= prod_vld_r; latency ifmap_vld_i -> psum_vld_o = 2 cycles.
REQ-023 OS_ACC: acc <= acc + prod_r when prod_vld_r; psum_o <= psum_i, psum_vld_o <= psum_vld_i (1-cycle pass-through for downstream drain chain).
REQ-024 acc_clr_i in OS_ACC: acc <= prod_vld_r ? prod_r : 0, ovf_o <= 0.
REQ-025 drain_i in OS_ACC -> OS_FLUSH (1 cycle, last in-flight product accumulated) -> OS_DRAIN (psum_o <= acc, psum_vld_o <= 1, acc <= prod_vld_r ? prod_r : 0) -> OS_ACC; drain_i outside OS_ACC ignored.
REQ-026 Accumulation continues during OS_FLUSH; pass-through psum_vld_i during OS_DRAIN is a protocol violation: own drain wins, incoming word dropped.
REQ-027 SATURATE=1: any sum exceeding range clamps to max/min (signed: 2^(P-1)-1 / -2^(P-1); unsigned: 2^P-1) and sets ovf_o; SATURATE=0: modulo 2^PSUM_WIDTH, ovf_o still set on overflow.
REQ-028 ovf_o cleared only by reset or acc_clr_i.
REQ-029 psum_vld_o low in any cycle with no valid result; psum_o holds last value.

Reset
REQ-030 rst_n low: all registers (shadow, active, prod_r, psum_r, acc, outputs) to 0, all valids/strobes/busy_o/ovf_o to 0, FSM to WS, effective immediately.
REQ-031 Reset mid-drain or mid-pipeline discards all in-flight data; no psum_vld_o pulse after release until new valid input.

Verification
REQ-032 WS, SIGNED=1: load 3, swap, ifmap -4, psum_i 10 -> psum_o -2, psum_vld_o exactly 2 cycles later.
REQ-033 Double buffer: compute with active=2 while loading 5, swap mid-stream -> products switch multiplier on cycle after swap; weight_o=5 one cycle after load.
REQ-034 OS: weight 2, ifmap 1,2,3,4 consecutive, drain_i -> busy_o 2 cycles, psum_o=20, psum_vld_o single pulse, acc then 0.
REQ-035 Saturation, PSUM_WIDTH=16, signed: accumulate 127*127 three times -> psum_o 32767, ovf_o=1 until acc_clr_i.
REQ-036 Assert rst_n during OS_FLUSH -> all outputs 0 immediately, state WS after release, no stray psum_vld_o.
